icache_data_ram_par: RTL
========================

Name: icache_data_ram_par

Overview:
Parametrised, single-clock successor to the icache data SRAM model: one write port (0) and one read port (1), synthesizable register-array storage.
- Adds byte-lane write masking and per-byte even parity with a read-side error flag.
- Adds a post-reset clear sequencer, same-address write-to-read bypass, and a selectable 1- or 2-cycle read latency.
- Sits between the icache fill/fetch logic and the data array; the parity flag feeds the processor's error-resilience path.

Parameters:
DATA_WIDTH, 64, word width; must be a multiple of 8; NBYTES = DATA_WIDTH/8
ADDR_WIDTH, 5, address bits; DEPTH = 1<<ADDR_WIDTH words
READ_LAT, 1, read latency in cycles, 1 or 2 (2 adds an output register)
BYPASS, 1, 1 = same-cycle same-address read returns new data; 0 = returns old data
CNT_WIDTH, 8, width of the saturating parity-error counter

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
csb0  in  1  write chip select, active low
addr0  in  ADDR_WIDTH  write address
din0  in  DATA_WIDTH  write data
wmask0  in  NBYTES  byte write enables, 1 = write lane
inj_err0  in  1  when set with a write, inverts stored parity of every written byte
csb1  in  1  read chip select, active low
addr1  in  ADDR_WIDTH  read address
dout1  out  DATA_WIDTH  read data
dout1_valid  out  1  one-cycle pulse, dout1 and perr1 valid
perr1  out  1  parity mismatch on at least one byte of dout1; qualified by dout1_valid
init_busy  out  1  clear sequence in progress; ports ignored while high
err_cnt  out  CNT_WIDTH  saturating count of valid reads with perr1=1

Behaviour:
- Reset (async assert, at any time, including mid-read or mid-clear):
  - dout1=0, dout1_valid=0, perr1=0, err_cnt=0, init_busy=1.
  - Read pipeline is flushed; no stale valid may emerge after reset.
- Clear FSM states: INIT and READY.
  - INIT writes word clr_ptr = 0 with parity 0 (all lanes) each cycle, then increments clr_ptr.
  - After writing DEPTH-1, the FSM goes to READY; init_busy falls after exactly DEPTH posedges following rst_n deassertion.
  - In INIT, csb0/csb1 are ignored: no write, no dout1_valid.
  - In READY, the FSM never leaves READY except on reset.
- Write, at posedge with csb0=0 in READY:
  - For each lane b with wmask0[b]=1: store din0 byte b and parity ^din0[b] ^ inj_err0.
  - Unmasked lanes are unchanged.
  - wmask0=0 is a legal no-op.
- Read, at posedge with csb1=0 in READY:
  - Address and data are captured.
  - READ_LAT=1: dout1/dout1_valid are updated at that same edge, so data is visible in the next cycle.
  - READ_LAT=2: one additional registered stage.
  - Back-to-back reads every cycle are sustained, with one result per cycle and no bubbles.
- perr1 = OR over bytes of (stored parity != ^stored byte).
- err_cnt increments on each dout1_valid with perr1=1 and saturates at all-ones.
- dout1 holds its last value when no read is active; it never goes X.
- Collision (csb0=0, csb1=0, addr0==addr1, same edge):
  - BYPASS=1: read data = merge, with masked lanes from din0 and other lanes from storage. Parity comes from the write path, so inj_err0 also propagates to perr1.
  - BYPASS=0: read returns pre-write contents.
  - The write always commits.
- Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists.

Decomposition:
- Package icache_ram_pkg holds:
  - the state enum (INIT, READY);
  - the byte-parity function;
  - the constant BYTE=8.
- One natural sub-module: icache_byte_parity (DATA_WIDTH in, NBYTES parity out, combinational), instantiated on the write path and the check path.
- Everything else stays in the top.

Test Plan:
- Clear sequence: deassert rst_n, DATA_WIDTH=64, ADDR_WIDTH=5 -> init_busy high for exactly 32 cycles. A read of addr 31 issued in cycle 33 returns 0, perr1=0, dout1_valid one cycle later. A write issued during INIT is discarded.
- Byte mask: write 0x1122334455667788 to addr 3, wmask0=0xFF; then write 0xAAAAAAAAAAAAAAAA with wmask0=0x0F; read addr 3 -> dout1=0x11223344AAAAAAAA, perr1=0.
- Collision: same edge write addr 7 = 0xDEADBEEF00000000 (mask 0xF0, prior contents 0) and read addr 7:
  - BYPASS=1 -> 0xDEADBEEF00000000;
  - BYPASS=0 -> 0.
  - A follow-up read returns 0xDEADBEEF00000000 in both builds.
- Error inject: write addr 10 with inj_err0=1, mask 0x01; read addr 10 three times -> perr1=1 each time, err_cnt=3. Rewrite lane 0 without inject -> perr1=0.
- Latency/throughput: READ_LAT=2, reads addr 0..7 on 8 consecutive cycles -> dout1_valid high for 8 consecutive cycles starting 2 cycles after the first read, data in address order.
- Reset mid-operation: assert rst_n=0 one cycle after a read with READ_LAT=2 -> no dout1_valid emerges; err_cnt=0; init_busy=1; clear sequence restarts from addr 0.

Source files
------------

// File: rtl/icache_ram_pkg.sv
// Shared definitions for the icache data RAM with byte parity.
//   state_e  : clear sequencer states (INIT clears the array, READY serves ports)
//   BYTE     : lane width in bits
//   byte_par : even parity of one byte (1 when the byte has an odd number of ones)
package icache_ram_pkg;

    localparam int BYTE = 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic logic byte_par(input logic [BYTE-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/icache_byte_parity.sv
// Combinational per-byte parity generator.
//   data : DATA_WIDTH-bit word
//   par  : one parity bit per byte lane, par[b] = ^data[b*8 +: 8]
module icache_byte_parity
    import icache_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]      data,
    output logic [DATA_WIDTH/BYTE-1:0] par
);

    localparam int NBYTES = DATA_WIDTH / BYTE;

    for (genvar b = 0; b < NBYTES; b++) begin : g_lane
        assign par[b] = byte_par(data[b*BYTE +: BYTE]);
    end

endmodule

// File: rtl/icache_data_ram_par.sv
// Icache data array: one write port (0), one read port (1), single clock.
// Byte-lane write masking, per-byte even parity with read-side error flag,
// post-reset clear sequencer, optional same-address bypass, 1- or 2-cycle
// read latency, and a saturating parity-error counter.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   csb0/addr0/din0/wmask0     : write port (active-low select, byte enables)
//   inj_err0                   : flip stored parity of every lane written
//   csb1/addr1                 : read port (active-low select)
//   dout1/dout1_valid/perr1    : read data, valid pulse, parity error flag
//   init_busy                  : array clear in progress, ports ignored
//   err_cnt                    : saturating count of reads returning perr1=1
//
// Read handshake: there is no backpressure. A read is accepted on every
// posedge where csb1 is low and init_busy is low; each accepted read produces
// exactly one single-cycle dout1_valid pulse READ_LAT edges later, in order.
module icache_data_ram_par
    import icache_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_LAT   = 1,
    parameter int BYPASS     = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       csb0,
    input  logic [ADDR_WIDTH-1:0]      addr0,
    input  logic [DATA_WIDTH-1:0]      din0,
    input  logic [DATA_WIDTH/BYTE-1:0] wmask0,
    input  logic                       inj_err0,
    input  logic                       csb1,
    input  logic [ADDR_WIDTH-1:0]      addr1,
    output logic [DATA_WIDTH-1:0]      dout1,
    output logic                       dout1_valid,
    output logic                       perr1,
    output logic                       init_busy,
    output logic [CNT_WIDTH-1:0]       err_cnt
);

    localparam int NBYTES = DATA_WIDTH / BYTE;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    // Clear sequencer
    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // DEPTH is a power of two, so the last word is the all-ones pointer.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (&clr_ptr) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    assign init_busy = (state == INIT);

    // Storage
    logic [DATA_WIDTH-1:0] mem     [DEPTH];
    logic [NBYTES-1:0]     par_mem [DEPTH];

    logic              wr_en, rd_en;
    logic [NBYTES-1:0] din_par, wr_par;

    assign wr_en = (state == READY) && !csb0;
    assign rd_en = (state == READY) && !csb1;

    icache_byte_parity #(.DATA_WIDTH(DATA_WIDTH)) u_wr_par (
        .data (din0),
        .par  (din_par)
    );

    assign wr_par = din_par ^ {NBYTES{inj_err0}};

    // No reset on the array itself; the INIT sweep zeroes data and parity.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_ptr]     <= '0;
            par_mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask0[b]) begin
                    mem[addr0][b*BYTE +: BYTE] <= din0[b*BYTE +: BYTE];
                    par_mem[addr0][b]          <= wr_par[b];
                end
            end
        end
    end

    // Read path: storage, optionally overlaid with the colliding write lanes.
    // Bypassed lanes take their parity from the write path so an injected
    // error is visible on the very read that collides with it.
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [NBYTES-1:0]     rd_par, rd_calc_par;
    logic                  rd_perr;

    assign collide = (BYPASS != 0) && wr_en && (addr0 == addr1);

    always_comb begin
        rd_data = mem[addr1];
        rd_par  = par_mem[addr1];
        if (collide) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask0[b]) begin
                    rd_data[b*BYTE +: BYTE] = din0[b*BYTE +: BYTE];
                    rd_par[b]               = wr_par[b];
                end
            end
        end
    end

    icache_byte_parity #(.DATA_WIDTH(DATA_WIDTH)) u_chk_par (
        .data (rd_data),
        .par  (rd_calc_par)
    );

    assign rd_perr = |(rd_calc_par ^ rd_par);

    // Optional extra stage; everything here resets so a flushed read
    // can never surface after reset.
    logic                  out_valid_nxt, out_perr_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;

    if (READ_LAT == 2) begin : g_lat2
        logic                  s1_valid, s1_perr;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_perr  <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= rd_en;
                if (rd_en) begin
                    s1_perr <= rd_perr;
                    s1_data <= rd_data;
                end
            end
        end

        assign out_valid_nxt = s1_valid;
        assign out_perr_nxt  = s1_perr;
        assign out_data_nxt  = s1_data;
    end else begin : g_lat1
        assign out_valid_nxt = rd_en;
        assign out_perr_nxt  = rd_perr;
        assign out_data_nxt  = rd_data;
    end

    // Output register and error counter; err_cnt moves on the same edge
    // that presents the erroneous read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1       <= '0;
            dout1_valid <= 1'b0;
            perr1       <= 1'b0;
            err_cnt     <= '0;
        end else begin
            dout1_valid <= out_valid_nxt;
            perr1       <= out_valid_nxt && out_perr_nxt;
            if (out_valid_nxt) dout1 <= out_data_nxt;
            if (out_valid_nxt && out_perr_nxt && (err_cnt != {CNT_WIDTH{1'b1}}))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
